// File: rtl/bit_serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default width.
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for bit_serial_adder.
// The sub port exists only when BIT_SERIAL_ADDER_SUB_EN is defined.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    modport master (
        output in_valid, in0, in1, cin, sub, out_ready,
        input  in_ready, out_valid, out, cout
    );

    modport slave (
        input  in_valid, in0, in1, cin, sub, out_ready,
        output in_ready, out_valid, out, cout
    );
`else
    modport master (
        output in_valid, in0, in1, cin, out_ready,
        input  in_ready, out_valid, out, cout
    );

    modport slave (
        input  in_valid, in0, in1, cin, out_ready,
        output in_ready, out_valid, out, cout
    );
`endif

endinterface

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full adder used as the shared arithmetic element of the serial adder.
module full_adder (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic out,
    output logic cout
);

    assign out  = in0 ^ in1 ^ in2;
    assign cout = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one bit per clock, LSB first, through one full_adder with a registered carry.
// Optional subtract mode is enabled with the BIT_SERIAL_ADDER_SUB_EN macro.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bit_serial_adder_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] count_q;

    logic             sum_bit;
    logic             next_carry;
    logic             last_bit;
    logic [WIDTH:0]   result_shift;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_full_adder (
        .in0  (a_q[0]),
        .in1  (b_q[0]),
        .in2  (carry_q),
        .out  (sum_bit),
        .cout (next_carry)
    );

    assign last_bit     = (count_q == CNT_W'(WIDTH - 1));
    assign result_shift = {sum_bit, result_q};

    // Subtraction is a + ~b + 1, so the carry flop is forced high and cin is ignored.
`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.in1 : bus.in1;
    assign carry_load = bus.sub | bus.cin;
`else
    assign b_load     = bus.in1;
    assign carry_load = bus.cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in0;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        count_q <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_shift[WIDTH:1];
                    carry_q  <= next_carry;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                    if (last_bit) begin
                        cout_q <= next_carry;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = result_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances).
// Subtract vectors run only when BIT_SERIAL_ADDER_SUB_EN is defined.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_adder_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_if #(.WIDTH(1)) bus1 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then scramble them to prove they were sampled once.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        checkOutput("accept_ready", 32'(bus8.in_ready), 32'd1);
        bus8.in0      = a;
        bus8.in1      = b;
        bus8.cin      = c;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.in0      = 8'hEE;
        bus8.in1      = 8'h77;
        bus8.cin      = ~c;
    endtask

    task automatic waitResult(input string tag, input int exp_lat, output logic saw_ready);
        int n;
        n         = 0;
        saw_ready = 1'b0;
        while (n < 20) begin
            tick();
            n++;
            if (bus8.in_ready) saw_ready = 1'b1;
            if (bus8.out_valid) break;
        end
        if (!bus8.out_valid) n = 99;
        checkOutput({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        logic rdy;
        int   n1;

        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in0       = 8'h00;
        bus8.in1       = 8'h00;
        bus8.cin       = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in0       = 1'b0;
        bus1.in1       = 1'b0;
        bus1.cin       = 1'b0;
        bus1.out_ready = 1'b1;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b0;
        bus1.sub = 1'b0;
`endif
        tick();
        tick();

        checkOutput("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("rst_out",       32'(bus8.out),       32'h00);
        checkOutput("rst_cout",      32'(bus8.cout),      32'd0);
        checkOutput("rst1_in_ready", 32'(bus1.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Zero-wait consumer; out_ready high in IDLE/RUN must be harmless.
        bus8.out_ready = 1'b1;
        applyStimulus(8'h3C, 8'h05, 1'b0);
        waitResult("t1", 8, rdy);
        checkOutput("t1_out",  32'(bus8.out),  32'h41);
        checkOutput("t1_cout", 32'(bus8.cout), 32'd0);
        tick();
        checkOutput("t1_valid_drop", 32'(bus8.out_valid), 32'd0);
        checkOutput("t1_ready_back", 32'(bus8.in_ready),  32'd1);
        checkOutput("t1_out_held",   32'(bus8.out),       32'h41);

        applyStimulus(8'hFF, 8'h01, 1'b1);
        waitResult("t2", 8, rdy);
        checkOutput("t2_in_ready_low", 32'(rdy),       32'd0);
        checkOutput("t2_out",          32'(bus8.out),  32'h01);
        checkOutput("t2_cout",         32'(bus8.cout), 32'd1);
        tick();
        checkOutput("t2_cout_held", 32'(bus8.cout), 32'd1);

        // Backpressure with stray operand pulses during the stall.
        bus8.out_ready = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b0);
        waitResult("t3", 8, rdy);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = (i % 2 == 0);
            bus8.in0      = 8'h11;
            bus8.in1      = 8'h11;
            tick();
            checkOutput("t3_stall_valid", 32'(bus8.out_valid), 32'd1);
            checkOutput("t3_stall_out",   32'(bus8.out),       32'h00);
            checkOutput("t3_stall_cout",  32'(bus8.cout),      32'd1);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        checkOutput("t3_valid_drop", 32'(bus8.out_valid), 32'd0);
        checkOutput("t3_ready_back", 32'(bus8.in_ready),  32'd1);
        checkOutput("t3_out_held",   32'(bus8.out),       32'h00);

        // Reset mid-RUN after bits 0..3 have been processed.
        applyStimulus(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t4_running", 32'(bus8.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        checkOutput("t4_in_ready",  32'(bus8.in_ready),  32'd1);
        checkOutput("t4_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("t4_out",       32'(bus8.out),       32'h00);
        checkOutput("t4_cout",      32'(bus8.cout),      32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h01, 8'h01, 1'b0);
        waitResult("t4b", 8, rdy);
        checkOutput("t4b_out",  32'(bus8.out),  32'h02);
        checkOutput("t4b_cout", 32'(bus8.cout), 32'd0);
        tick();

        // WIDTH=1: a single RUN cycle.
        bus1.in0      = 1'b1;
        bus1.in1      = 1'b1;
        bus1.cin      = 1'b1;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        bus1.in0      = 1'b0;
        bus1.in1      = 1'b0;
        bus1.cin      = 1'b0;
        n1 = 0;
        while (n1 < 10) begin
            tick();
            n1++;
            if (bus1.out_valid) break;
        end
        if (!bus1.out_valid) n1 = 99;
        checkOutput("t5_latency", 32'(n1),        32'd1);
        checkOutput("t5_out",     32'(bus1.out),  32'd1);
        checkOutput("t5_cout",    32'(bus1.cout), 32'd1);
        tick();
        checkOutput("t5_valid_drop", 32'(bus1.out_valid), 32'd0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b1;
        applyStimulus(8'h10, 8'h01, 1'b0);
        bus8.sub = 1'b0;
        waitResult("t6a", 8, rdy);
        checkOutput("t6a_out",  32'(bus8.out),  32'h0F);
        checkOutput("t6a_cout", 32'(bus8.cout), 32'd1);
        tick();
        bus8.sub = 1'b1;
        applyStimulus(8'h01, 8'h02, 1'b0);
        bus8.sub = 1'b0;
        waitResult("t6b", 8, rdy);
        checkOutput("t6b_out",  32'(bus8.out),  32'hFF);
        checkOutput("t6b_cout", 32'(bus8.cout), 32'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
